// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes and transmitter handshake shared by uart_tx_arbiter and its environment.
// The arbiter uses the slave view; whatever drives requesters and models the serializer uses master.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_start, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one byte-serial UART transmitter among N requesters.
// Ownership ends on a last byte, after MaxBurst bytes, or after HoldCycles stalled cycles in ARMED.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int MaxBurst   = 16,
    parameter int HoldCycles = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int PW = $clog2(N);
    localparam int SW = $clog2(HoldCycles);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARMED     = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          last_q, last_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic          owner_ready;
    logic          handshake;
    logic [7:0]    owner_byte;

    // First valid requester at or above ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_q) + i) % N);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign owner_ready = (state_q == S_ARMED) && !bus.tx_busy && bus.req_valid[owner_q];
    assign handshake   = owner_ready;
    assign owner_byte  = bus.req_data[{owner_q, 3'b000} +: 8];

    always_comb begin
        bus.req_ready          = '0;
        bus.req_ready[owner_q] = owner_ready;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        byte_cnt_d  = byte_cnt_q;
        stall_cnt_d = stall_cnt_q;
        last_d      = last_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    byte_cnt_d    = '0;
                    stall_cnt_d   = '0;
                    state_d       = S_ARMED;
                end
            end
            S_ARMED: begin
                if (handshake) begin
                    tx_data_d   = owner_byte;
                    last_d      = bus.req_last[owner_q] |
                                  (({1'b0, byte_cnt_q} + 9'd1) == 9'(MaxBurst));
                    byte_cnt_d  = byte_cnt_q + 8'd1;
                    stall_cnt_d = '0;
                    tx_start_d  = 1'b1;
                    state_d     = S_START;
                end else if (stall_cnt_q == SW'(HoldCycles - 1)) begin
                    grant_d = '0;
                    ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
                    state_d = S_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
            last_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            last_q      <= last_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a packet-level round-robin reference model.
// Requester lanes, a busy-pulse transmitter model and an output monitor run as separate processes.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 16;
    localparam int HC = 16;

    typedef struct packed {
        logic [N-1:0] g;
        logic [7:0]   d;
    } exp_t;

    logic clk;
    logic rst_n;
    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(.N(N), .MaxBurst(MB), .HoldCycles(HC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t       sb[$];
    logic [8:0] lane_q[N][$];
    bit         muted[N];
    int         stall_lane = -1;
    logic [N-1:0] hs_v;
    int         m_ptr  = 0;
    int         checks = 0;
    int         errors = 0;
    int         xmt_len = 0;
    int         start_cyc[$];
    int         cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every queued byte is presented continuously, so service order
    // follows round-robin over non-empty lanes, one packet or MB bytes per grant.
    task automatic schedule();
        logic [8:0] mq[N][$];
        logic [8:0] e;
        int o, cnt;
        bit any;
        mq = lane_q;
        forever begin
            any = 0;
            o = 0;
            for (int k = 0; k < N; k++) begin
                if (!any && mq[(m_ptr + k) % N].size() > 0) begin
                    any = 1;
                    o = (m_ptr + k) % N;
                end
            end
            if (!any) break;
            cnt = 0;
            do begin
                e = mq[o].pop_front();
                sb.push_back('{g: N'(1) << o, d: e[7:0]});
                cnt++;
            end while (!e[8] && cnt < MB && mq[o].size() > 0);
            m_ptr = (o + 1) % N;
        end
    endtask

    task automatic drive();
        logic [N-1:0]   v, l;
        logic [8*N-1:0] d;
        for (int i = 0; i < N; i++) begin
            if (hs_v[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            if (stall_lane == i && bus.grant[i]) muted[i] = 1;
            d[8*i +: 8] = 8'($urandom);
            l[i] = 1'($urandom);
            if (lane_q[i].size() > 0) begin
                v[i] = !muted[i];
                if (bus.grant[i]) begin
                    d[8*i +: 8] = lane_q[i][0][7:0];
                    l[i] = lane_q[i][0][8];
                end
            end else begin
                v[i] = (bus.grant != '0) ? 1'($urandom) : 1'b0;
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
    endtask

    task automatic step();
        @(negedge clk);
        hs_v = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() > 0 || bus.grant != '0 || bus.tx_busy) && n < 5000) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, (n >= 5000) ? 1 : 0, 0);
        chk({name, "_left"}, sb.size(), 0);
    endtask

    // Transmitter: busy rises the cycle after tx_start is sampled and lasts len cycles.
    initial begin
        int len;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                len = (xmt_len > 0) ? xmt_len : int'($urandom_range(1, 6));
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ready_nonowner", 32'(bus.req_ready & ~bus.grant), 0);
                chk("ready_while_busy", bus.tx_busy ? 32'(bus.req_ready) : 0, 0);
                if (bus.tx_start) begin
                    start_cyc.push_back(cyc);
                    chk("start_while_busy", 32'(bus.tx_busy), 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got data 0x%0h grant 0x%0h, expected no start",
                                 bus.tx_data, bus.grant);
                    end else begin
                        e = sb.pop_front();
                        chk("tx_data", 32'(bus.tx_data), 32'(e.d));
                        chk("grant", 32'(bus.grant), 32'(e.g));
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, cnt, np, len;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        hs_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        lane_q[0].push_back(9'h041);
        lane_q[0].push_back(9'h042);
        lane_q[0].push_back(9'h143);
        schedule();
        start_cyc.delete();
        step();
        t0 = cyc;
        drain("single");
        chk("arb_latency", (start_cyc.size() > 0) ? start_cyc[0] - t0 : -1, 2);

        lane_q[0].push_back(9'h110);
        lane_q[0].push_back(9'h111);
        lane_q[2].push_back(9'h120);
        schedule();
        drain("two_req");

        for (int b = 1; b <= 20; b++) lane_q[1].push_back({(b == 20), 8'(b)});
        lane_q[3].push_back(9'h0C0);
        lane_q[3].push_back(9'h1C1);
        schedule();
        drain("burst");

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    np = $urandom_range(1, 2);
                    for (int p = 0; p < np; p++) begin
                        len = $urandom_range(1, 20);
                        for (int b = 0; b < len; b++)
                            lane_q[i].push_back({(b == len - 1), 8'($urandom)});
                    end
                end
            end
            schedule();
            drain("random");
        end

        lane_q[2].push_back(9'h199);
        stall_lane = 2;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.grant[2] && n < 50);
        cnt = 0;
        while (bus.grant[2] && cnt < 200) begin
            cnt++;
            step();
        end
        chk("stall_hold_cycles", cnt, HC);
        chk("stall_release", 32'(bus.grant), 0);
        lane_q[2].delete();
        muted[2] = 0;
        stall_lane = -1;
        m_ptr = 3;
        repeat (3) step();

        xmt_len = 20;
        lane_q[1].push_back(9'h05A);
        lane_q[1].push_back(9'h15B);
        sb.push_back('{g: 4'b0010, d: 8'h5A});
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tx_busy && n < 50);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(bus.grant), 0);
        chk("async_rst_tx_data", 32'(bus.tx_data), 0);
        chk("async_rst_tx_start", 32'(bus.tx_start), 0);
        chk("async_rst_ready", 32'(bus.req_ready), 0);
        lane_q[1].delete();
        bus.req_valid = '0;
        lane_q[3].push_back(9'h177);
        sb.push_back('{g: 4'b1000, d: 8'h77});
        m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.grant[3] && n < 50);
        chk("regrant_busy_held", 32'(bus.tx_busy), 1);
        chk("regrant_ready_gated", 32'(bus.req_ready), 0);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
